// File: rtl/bwe_ram_pkg.sv
// rtl/bwe_ram_pkg.sv - shared types and constants for the byte-write-enable RAM arbiter
package bwe_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_SIZE       = 512;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DI_WIDTH   = 8;

endpackage

// File: rtl/bwe_ram_arbiter_if.sv
// rtl/bwe_ram_arbiter_if.sv - two-requester client bus of the shared RAM arbiter
interface bwe_ram_arbiter_if
  import bwe_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DI_WIDTH   = DEF_DI_WIDTH
);

  logic                    a_valid;
  logic                    a_ready;
  logic [1:0]              a_we;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [2*DI_WIDTH-1:0]   a_di;
  logic                    a_rvalid;

  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_we;
  logic [ADDR_WIDTH-1:0]   b_addr;
  logic [2*DI_WIDTH-1:0]   b_di;
  logic                    b_rvalid;

  logic [2*DI_WIDTH-1:0]   rdata;
  logic                    init_done;

  modport master (
    output a_valid, a_we, a_addr, a_di,
    output b_valid, b_we, b_addr, b_di,
    input  a_ready, a_rvalid, b_ready, b_rvalid, rdata, init_done
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_di,
    input  b_valid, b_we, b_addr, b_di,
    output a_ready, a_rvalid, b_ready, b_rvalid, rdata, init_done
  );

endinterface

// File: rtl/bwe_ram_sp.sv
// rtl/bwe_ram_sp.sv - single-port two-lane byte-write-enable write-first RAM, registered output
module bwe_ram_sp
  import bwe_ram_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DI_WIDTH   = DEF_DI_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2*DI_WIDTH-1:0] di,
  output logic [2*DI_WIDTH-1:0] dout
);

  logic [2*DI_WIDTH-1:0] mem [SIZE];

  // Disabled port keeps dout, so the last response stays visible while idle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (we[i]) begin
          mem[addr][i*DI_WIDTH +: DI_WIDTH] <= di[i*DI_WIDTH +: DI_WIDTH];
          dout[i*DI_WIDTH +: DI_WIDTH]      <= di[i*DI_WIDTH +: DI_WIDTH];
        end else begin
          dout[i*DI_WIDTH +: DI_WIDTH]      <= mem[addr][i*DI_WIDTH +: DI_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/bwe_ram_arbiter.sv
// rtl/bwe_ram_arbiter.sv - round-robin two-requester sequencer with zero-fill sweep for a shared BWE RAM
module bwe_ram_arbiter
  import bwe_ram_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DI_WIDTH   = DEF_DI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  bwe_ram_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_addr;
  logic                    init_done_q;
  logic                    last;
  logic                    rsp_valid;
  logic                    rsp_id;
  logic                    rdata_clr;

  logic                    granted;
  logic                    grant;
  logic                    ram_en;
  logic [1:0]              ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [2*DI_WIDTH-1:0]   ram_di;
  logic [2*DI_WIDTH-1:0]   ram_dout;

  always_comb begin
    granted = 1'b0;
    grant   = REQ_A;
    if (state == ST_RUN) begin
      if (bus.a_valid && bus.b_valid) begin
        granted = 1'b1;
        grant   = (last == REQ_A) ? REQ_B : REQ_A;
      end else if (bus.a_valid) begin
        granted = 1'b1;
        grant   = REQ_A;
      end else if (bus.b_valid) begin
        granted = 1'b1;
        grant   = REQ_B;
      end
    end
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 2'b00;
    ram_addr = init_addr;
    ram_di   = '0;
    if (state == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = 2'b11;
    end else if (granted) begin
      ram_en   = 1'b1;
      ram_we   = (grant == REQ_A) ? bus.a_we   : bus.b_we;
      ram_addr = (grant == REQ_A) ? bus.a_addr : bus.b_addr;
      ram_di   = (grant == REQ_A) ? bus.a_di   : bus.b_di;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      init_addr   <= '0;
      init_done_q <= 1'b0;
      last        <= REQ_B;
      rsp_valid   <= 1'b0;
      rsp_id      <= REQ_A;
      rdata_clr   <= 1'b1;
    end else begin
      rsp_valid <= granted;
      if (granted) begin
        rsp_id    <= grant;
        last      <= grant;
        rdata_clr <= 1'b0;
      end
      case (state)
        ST_INIT: begin
          if (init_addr == LAST_ADDR) begin
            state       <= ST_RUN;
            init_done_q <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  bwe_ram_sp #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DI_WIDTH   (DI_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .di   (ram_di),
    .dout (ram_dout)
  );

  // The RAM output has no reset; mask it until the first granted access lands.
  assign bus.rdata     = rdata_clr ? '0 : ram_dout;
  assign bus.a_ready   = granted && (grant == REQ_A);
  assign bus.b_ready   = granted && (grant == REQ_B);
  assign bus.a_rvalid  = rsp_valid && (rsp_id == REQ_A);
  assign bus.b_rvalid  = rsp_valid && (rsp_id == REQ_B);
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_bwe_ram_arbiter.sv
// tb/tb_bwe_ram_arbiter.sv - directed table-driven bench for the BWE RAM arbiter
module tb_bwe_ram_arbiter;

  typedef struct {
    logic        av;
    logic [1:0]  awe;
    logic [8:0]  aaddr;
    logic [15:0] adi;
    logic        bv;
    logic [1:0]  bwe;
    logic [8:0]  baddr;
    logic [15:0] bdi;
    logic        ea_rdy;
    logic        eb_rdy;
    logic        ea_rv;
    logic        eb_rv;
    logic        chk_rd;
    logic [15:0] e_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[23];

  always #5 clk = ~clk;

  bwe_ram_arbiter_if #(.ADDR_WIDTH(9), .DI_WIDTH(8)) bus ();

  bwe_ram_arbiter #(.SIZE(512), .ADDR_WIDTH(9), .DI_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(
    input logic av, input logic [1:0] awe, input logic [8:0] aaddr, input logic [15:0] adi,
    input logic bv, input logic [1:0] bwe, input logic [8:0] baddr, input logic [15:0] bdi,
    input logic ea_rdy, input logic eb_rdy, input logic ea_rv, input logic eb_rv,
    input logic chk_rd, input logic [15:0] e_rd);
    vec_t v;
    v.av = av; v.awe = awe; v.aaddr = aaddr; v.adi = adi;
    v.bv = bv; v.bwe = bwe; v.baddr = baddr; v.bdi = bdi;
    v.ea_rdy = ea_rdy; v.eb_rdy = eb_rdy; v.ea_rv = ea_rv; v.eb_rv = eb_rv;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [1:0] we, input logic [8:0] addr, input logic [15:0] di);
    bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_di = di;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] we, input logic [8:0] addr, input logic [15:0] di);
    bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_di = di;
  endtask

  // Holds A reading addr while the 512-cycle sweep runs, then expects readiness on cycle 513.
  task automatic sweep_check(input string tag, input logic [8:0] addr);
    drive_a(1'b1, 2'b00, addr, 16'h0);
    #1;
    for (int i = 1; i <= 512; i++) begin
      chk({tag, "_a_ready_init"}, bus.a_ready, 1'b0);
      chk({tag, "_init_done_low"}, bus.init_done, 1'b0);
      chk({tag, "_a_rvalid_init"}, bus.a_rvalid, 1'b0);
      tick();
    end
    chk({tag, "_init_done_high"}, bus.init_done, 1'b1);
    chk({tag, "_a_ready_run"}, bus.a_ready, 1'b1);
    chk({tag, "_b_ready_run"}, bus.b_ready, 1'b0);
    tick();
    drive_a(1'b0, 2'b00, 9'd0, 16'h0);
    #1;
    chk({tag, "_a_rvalid_rsp"}, bus.a_rvalid, 1'b1);
    chk({tag, "_b_rvalid_rsp"}, bus.b_rvalid, 1'b0);
    chk({tag, "_rdata_zero"}, bus.rdata, 16'h0000);
    tick();
  endtask

  initial begin
    //            A: v we    addr   di        B: v we    addr   di        rdy  rv   rd
    tbl[0]  = mk(1, 2'b11, 9'd3, 16'hA55A, 0, 2'b00, 9'd0, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 2'b10, 9'd3, 16'h1234, 0, 2'b00, 9'd0, 16'h0000, 1, 0, 1, 0, 1, 16'hA55A);
    tbl[2]  = mk(1, 2'b00, 9'd3, 16'h0000, 0, 2'b00, 9'd0, 16'h0000, 1, 0, 1, 0, 1, 16'h125A);
    tbl[3]  = mk(0, 2'b00, 9'd0, 16'h0000, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 1, 0, 1, 16'h125A);
    tbl[4]  = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b11, 9'd7, 16'h1100, 0, 1, 0, 0, 0, 16'h0000);
    tbl[5]  = mk(1, 2'b01, 9'd7, 16'h00CC, 0, 2'b00, 9'd0, 16'h0000, 1, 0, 0, 1, 1, 16'h1100);
    tbl[6]  = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 0, 1, 1, 0, 1, 16'h11CC);
    tbl[7]  = mk(0, 2'b00, 9'd0, 16'h0000, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h11CC);
    tbl[8]  = mk(1, 2'b00, 9'd3, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
    tbl[9]  = mk(1, 2'b00, 9'd3, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 0, 1, 1, 0, 1, 16'h125A);
    tbl[10] = mk(1, 2'b00, 9'd3, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 1, 0, 0, 1, 1, 16'h11CC);
    tbl[11] = mk(1, 2'b00, 9'd3, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 0, 1, 1, 0, 1, 16'h125A);
    tbl[12] = mk(1, 2'b00, 9'd3, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 1, 0, 0, 1, 1, 16'h11CC);
    tbl[13] = mk(1, 2'b00, 9'd3, 16'h0000, 1, 2'b00, 9'd7, 16'h0000, 0, 1, 1, 0, 1, 16'h125A);
    tbl[14] = mk(0, 2'b00, 9'd0, 16'h0000, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h11CC);
    tbl[15] = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b00, 9'd3, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
    tbl[16] = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b00, 9'd3, 16'h0000, 0, 1, 0, 1, 1, 16'h125A);
    tbl[17] = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b00, 9'd3, 16'h0000, 0, 1, 0, 1, 1, 16'h125A);
    tbl[18] = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b00, 9'd3, 16'h0000, 0, 1, 0, 1, 1, 16'h125A);
    tbl[19] = mk(1, 2'b00, 9'd7, 16'h0000, 1, 2'b00, 9'd3, 16'h0000, 1, 0, 0, 1, 1, 16'h125A);
    tbl[20] = mk(0, 2'b00, 9'd0, 16'h0000, 1, 2'b00, 9'd3, 16'h0000, 0, 1, 1, 0, 1, 16'h11CC);
    tbl[21] = mk(0, 2'b00, 9'd0, 16'h0000, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, 1, 1, 16'h125A);
    tbl[22] = mk(0, 2'b00, 9'd0, 16'h0000, 0, 2'b00, 9'd0, 16'h0000, 0, 0, 0, 0, 1, 16'h125A);

    drive_a(1'b0, 2'b00, 9'd0, 16'h0);
    drive_b(1'b0, 2'b00, 9'd0, 16'h0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_a_ready", bus.a_ready, 1'b0);
    chk("rst_b_ready", bus.b_ready, 1'b0);
    chk("rst_a_rvalid", bus.a_rvalid, 1'b0);
    chk("rst_b_rvalid", bus.b_rvalid, 1'b0);
    chk("rst_init_done", bus.init_done, 1'b0);
    chk("rst_rdata", bus.rdata, 16'h0000);

    rst = 1'b0;
    sweep_check("sweep", 9'd5);

    for (int i = 0; i < 23; i++) begin
      drive_a(tbl[i].av, tbl[i].awe, tbl[i].aaddr, tbl[i].adi);
      drive_b(tbl[i].bv, tbl[i].bwe, tbl[i].baddr, tbl[i].bdi);
      #1;
      chk($sformatf("row%0d_a_ready", i), bus.a_ready, tbl[i].ea_rdy);
      chk($sformatf("row%0d_b_ready", i), bus.b_ready, tbl[i].eb_rdy);
      chk($sformatf("row%0d_a_rvalid", i), bus.a_rvalid, tbl[i].ea_rv);
      chk($sformatf("row%0d_b_rvalid", i), bus.b_rvalid, tbl[i].eb_rv);
      if (tbl[i].chk_rd)
        chk($sformatf("row%0d_rdata", i), bus.rdata, tbl[i].e_rd);
      tick();
    end

    // Reset lands on the edge after an accepted write; the sweep must erase it.
    drive_a(1'b1, 2'b11, 9'd9, 16'hBEEF);
    drive_b(1'b0, 2'b00, 9'd0, 16'h0);
    #1;
    chk("midrst_a_ready", bus.a_ready, 1'b1);
    tick();
    drive_a(1'b0, 2'b00, 9'd0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_a_rvalid_dropped", bus.a_rvalid, 1'b0);
    chk("midrst_init_done_drop", bus.init_done, 1'b0);
    chk("midrst_rdata_zero", bus.rdata, 16'h0000);
    sweep_check("resweep", 9'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
